// File: rtl/i2c_typedefs.sv
// Shared command, state and width definitions for the I2C byte master.
package i2c_typedefs;

    localparam int I2C_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        CMD_START    = 3'd0,
        CMD_STOP     = 3'd1,
        CMD_WRITE    = 3'd2,
        CMD_READ_ACK = 3'd3,
        CMD_READ_NAK = 3'd4
    } i2c_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WR_BIT,
        WR_ACK,
        RD_BIT,
        RD_ACK,
        STOP,
        DONE
    } i2c_master_state_t;

endpackage

// File: rtl/i2c_quarter_timer.sv
// SCL quarter-period timer; freezes while a released SCL is held low.
module i2c_quarter_timer #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       scl_rel_i,
    input  logic       scl_i,
    output logic [1:0] qtr_o,
    output logic       last_o
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [1:0]    qtr_q;
    logic          hold;

    assign hold   = scl_rel_i & ~scl_i;
    assign last_o = en_i & ~hold & (cnt_q == CNT_MAX);
    assign qtr_o  = qtr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            qtr_q <= 2'd0;
        end else if (!en_i) begin
            cnt_q <= '0;
            qtr_q <= 2'd0;
        end else if (!hold) begin
            if (cnt_q == CNT_MAX) begin
                cnt_q <= '0;
                qtr_q <= qtr_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_byte_master.sv
// I2C master byte engine: turns START/STOP/WRITE/READ commands into
// open-drain SCL/SDA waveforms and returns one response per command.
module i2c_byte_master
    import i2c_typedefs::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd,
    input  logic [I2C_DATA_WIDTH-1:0] wr_data,
    output logic                      rsp_valid,
    output logic [I2C_DATA_WIDTH-1:0] rsp_data,
    output logic                      rsp_ack,
    output logic                      rsp_err,
    output logic                      bus_owned,
    input  logic                      scl_i,
    output logic                      scl_o,
    input  logic                      sda_i,
    output logic                      sda_o
);

    localparam int DW = I2C_DATA_WIDTH;
    localparam logic [2:0] BIT_LAST = 3'(DW - 1);

    i2c_master_state_t state_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic [DW-1:0]     rsp_data_q;
    logic              rsp_ack_q;
    logic              rsp_err_q;
    logic              bus_owned_q;
    logic              scl_o_q;
    logic              sda_o_q;
    logic [DW-1:0]     sr_q;
    logic [2:0]        bit_cnt_q;
    logic              rd_ack_q;
    logic              smp_q;

    logic       tmr_en;
    logic [1:0] qtr;
    logic       tmr_last;
    logic       st_ok;
    logic       sp_ok;
    logic       wr_ok;
    logic       rd_ok;

    assign tmr_en = (state_q != IDLE) && (state_q != DONE);

    assign st_ok = (cmd == CMD_START);
    assign sp_ok = (cmd == CMD_STOP) && bus_owned_q;
    assign wr_ok = (cmd == CMD_WRITE) && bus_owned_q;
    assign rd_ok = ((cmd == CMD_READ_ACK) || (cmd == CMD_READ_NAK))
                   && bus_owned_q;

    i2c_quarter_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (tmr_en),
        .scl_rel_i(scl_o_q),
        .scl_i    (scl_i),
        .qtr_o    (qtr),
        .last_o   (tmr_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ack_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            bus_owned_q <= 1'b0;
            scl_o_q     <= 1'b1;
            sda_o_q     <= 1'b1;
            sr_q        <= '0;
            bit_cnt_q   <= 3'd0;
            rd_ack_q    <= 1'b0;
            smp_q       <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        unique case (1'b1)
                            st_ok: begin
                                state_q <= START;
                                sda_o_q <= 1'b1;
                            end
                            sp_ok: begin
                                state_q <= STOP;
                                sda_o_q <= 1'b0;
                                scl_o_q <= 1'b0;
                            end
                            wr_ok: begin
                                state_q   <= WR_BIT;
                                sr_q      <= wr_data;
                                sda_o_q   <= wr_data[DW-1];
                                bit_cnt_q <= BIT_LAST;
                            end
                            rd_ok: begin
                                state_q   <= RD_BIT;
                                sda_o_q   <= 1'b1;
                                bit_cnt_q <= BIT_LAST;
                                rd_ack_q  <= (cmd == CMD_READ_ACK);
                            end
                            default: begin
                                state_q     <= DONE;
                                rsp_valid_q <= 1'b1;
                                rsp_err_q   <= 1'b1;
                                rsp_ack_q   <= 1'b0;
                            end
                        endcase
                    end
                end
                START: begin
                    if (tmr_last) begin
                        unique case (qtr)
                            2'd0: scl_o_q <= 1'b1;
                            2'd1: begin
                                // Someone else holds SDA: the start cannot be issued.
                                if (!sda_i) begin
                                    scl_o_q     <= 1'b1;
                                    sda_o_q     <= 1'b1;
                                    bus_owned_q <= 1'b0;
                                    state_q     <= DONE;
                                    rsp_valid_q <= 1'b1;
                                    rsp_err_q   <= 1'b1;
                                    rsp_ack_q   <= 1'b0;
                                end else begin
                                    sda_o_q <= 1'b0;
                                end
                            end
                            2'd2: scl_o_q <= 1'b0;
                            default: begin
                                bus_owned_q <= 1'b1;
                                state_q     <= DONE;
                                rsp_valid_q <= 1'b1;
                                rsp_err_q   <= 1'b0;
                                rsp_ack_q   <= 1'b0;
                            end
                        endcase
                    end
                end
                WR_BIT: begin
                    if (tmr_last) begin
                        unique case (qtr)
                            2'd0: scl_o_q <= 1'b1;
                            2'd2: begin
                                if (sda_o_q && !sda_i) begin
                                    scl_o_q     <= 1'b1;
                                    sda_o_q     <= 1'b1;
                                    bus_owned_q <= 1'b0;
                                    state_q     <= DONE;
                                    rsp_valid_q <= 1'b1;
                                    rsp_err_q   <= 1'b1;
                                    rsp_ack_q   <= 1'b0;
                                end
                            end
                            2'd3: begin
                                scl_o_q <= 1'b0;
                                if (bit_cnt_q == 3'd0) begin
                                    state_q <= WR_ACK;
                                    sda_o_q <= 1'b1;
                                end else begin
                                    bit_cnt_q <= bit_cnt_q - 3'd1;
                                    sr_q      <= {sr_q[DW-2:0], 1'b0};
                                    sda_o_q   <= sr_q[DW-2];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                WR_ACK: begin
                    if (tmr_last) begin
                        unique case (qtr)
                            2'd0: scl_o_q <= 1'b1;
                            2'd2: smp_q <= ~sda_i;
                            2'd3: begin
                                scl_o_q     <= 1'b0;
                                state_q     <= DONE;
                                rsp_valid_q <= 1'b1;
                                rsp_err_q   <= 1'b0;
                                rsp_ack_q   <= smp_q;
                            end
                            default: ;
                        endcase
                    end
                end
                RD_BIT: begin
                    if (tmr_last) begin
                        unique case (qtr)
                            2'd0: scl_o_q <= 1'b1;
                            2'd2: sr_q <= {sr_q[DW-2:0], sda_i};
                            2'd3: begin
                                scl_o_q <= 1'b0;
                                if (bit_cnt_q == 3'd0) begin
                                    state_q <= RD_ACK;
                                    sda_o_q <= ~rd_ack_q;
                                end else begin
                                    bit_cnt_q <= bit_cnt_q - 3'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                RD_ACK: begin
                    if (tmr_last) begin
                        unique case (qtr)
                            2'd0: scl_o_q <= 1'b1;
                            2'd3: begin
                                scl_o_q     <= 1'b0;
                                state_q     <= DONE;
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= sr_q;
                                rsp_err_q   <= 1'b0;
                                rsp_ack_q   <= rd_ack_q;
                            end
                            default: ;
                        endcase
                    end
                end
                STOP: begin
                    if (tmr_last) begin
                        unique case (qtr)
                            2'd0: scl_o_q <= 1'b1;
                            2'd1: sda_o_q <= 1'b1;
                            2'd3: begin
                                bus_owned_q <= 1'b0;
                                state_q     <= DONE;
                                rsp_valid_q <= 1'b1;
                                rsp_err_q   <= 1'b0;
                                rsp_ack_q   <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_ack   = rsp_ack_q;
    assign rsp_err   = rsp_err_q;
    assign bus_owned = bus_owned_q;
    assign scl_o     = scl_o_q;
    assign sda_o     = sda_o_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master with a small clocked I2C slave at 7'h22.
module tb_i2c_byte_master;
    import i2c_typedefs::*;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd = 3'd0;
    logic [7:0] wr_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_ack;
    logic       rsp_err;
    logic       bus_owned;
    logic       scl_o;
    logic       sda_o;
    logic       scl_i;
    logic       sda_i;

    logic stretch = 1'b0;
    logic force0 = 1'b0;
    logic s_sda = 1'b1;

    int checks = 0;
    int failures = 0;
    int nrsp = 0;

    always #5 clk = ~clk;

    assign scl_i = scl_o & ~stretch;
    assign sda_i = sda_o & s_sda & ~force0;

    i2c_byte_master #(
        .CLK_DIV(DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd      (cmd),
        .wr_data  (wr_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_ack  (rsp_ack),
        .rsp_err  (rsp_err),
        .bus_owned(bus_owned),
        .scl_i    (scl_i),
        .scl_o    (scl_o),
        .sda_i    (sda_i),
        .sda_o    (sda_o)
    );

    always @(negedge clk) if (rsp_valid) nrsp <= nrsp + 1;

    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    logic       addr_ph = 1'b0;
    logic       rd_mode = 1'b0;
    logic       sel = 1'b0;
    logic       mack = 1'b0;
    logic [7:0] sh = 8'h00;
    logic [7:0] rdata [2];
    logic [7:0] wq [$];
    int         bcnt = 0;
    int         ridx = 0;
    int         starts = 0;
    int         stops = 0;

    initial begin
        rdata[0] = 8'h5A;
        rdata[1] = 8'hC3;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            s_sda = 1'b1;
            sel = 1'b0;
            addr_ph = 1'b0;
            bcnt = 0;
        end else if (scl_i && p_scl && p_sda && !sda_i) begin
            starts++;
            addr_ph = 1'b1;
            sel = 1'b0;
            bcnt = 0;
            s_sda = 1'b1;
        end else if (scl_i && p_scl && !p_sda && sda_i) begin
            stops++;
            addr_ph = 1'b0;
            sel = 1'b0;
            s_sda = 1'b1;
        end else if (scl_i && !p_scl) begin
            if (bcnt < 8) sh = {sh[6:0], sda_i};
            else mack = ~sda_i;
            bcnt++;
        end else if (!scl_i && p_scl) begin
            if (bcnt == 8) begin
                if (addr_ph) begin
                    sel = (sh[7:1] == 7'h22);
                    rd_mode = sh[0];
                    ridx = 0;
                    if (sel) s_sda = 1'b0;
                end else if (sel && !rd_mode) begin
                    wq.push_back(sh);
                    s_sda = 1'b0;
                end else begin
                    s_sda = 1'b1;
                end
            end else if (bcnt == 9) begin
                bcnt = 0;
                s_sda = 1'b1;
                if (addr_ph) addr_ph = 1'b0;
                else if (sel && rd_mode) begin
                    if (mack) ridx++;
                    else sel = 1'b0;
                end
                if (sel && rd_mode && ridx < 2) s_sda = rdata[ridx][7];
            end else if (bcnt > 0 && sel && rd_mode && !addr_ph) begin
                s_sda = rdata[ridx][7 - bcnt];
            end
        end
        p_scl = scl_i;
        p_sda = sda_i;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] c, input logic [7:0] d,
                         output int lat);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd = c;
        wr_data = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_scl_rises(input int n);
        int k;
        int t;
        logic p;
        k = 0;
        t = 0;
        p = scl_o;
        while (k < n && t < 2000) begin
            @(posedge clk);
            #1;
            if (scl_o && !p) k++;
            p = scl_o;
            t++;
        end
        if (k < n) chk("scl_timeout", 32'(k), 32'(n));
    endtask

    int lat;
    int base;

    initial begin
        #12;
        chk("rst_scl", 32'(scl_o), 32'd1);
        chk("rst_sda", 32'(sda_o), 32'd1);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp", 32'({rsp_valid, rsp_ack, rsp_err, bus_owned}), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        issue(CMD_WRITE, 8'h44, lat);
        chk("ill_lat", 32'(lat), 32'd0);
        chk("ill_err", 32'(rsp_err), 32'd1);
        chk("ill_lines", 32'({scl_o, sda_o}), 32'd3);
        @(posedge clk);
        #1 chk("ill_lines2", 32'({scl_o, sda_o, bus_owned}), 32'd6);

        issue(CMD_START, 8'h00, lat);
        chk("st_lat", 32'(lat), 32'(4 * DIV));
        chk("st_err", 32'(rsp_err), 32'd0);
        chk("st_own", 32'(bus_owned), 32'd1);
        chk("st_seen", 32'(starts), 32'd1);

        issue(CMD_WRITE, 8'h44, lat);
        chk("wa_lat", 32'(lat), 32'(36 * DIV));
        chk("wa_ackerr", 32'({rsp_ack, rsp_err}), 32'd2);
        chk("wa_addr", 32'({sel, rd_mode}), 32'd2);

        issue(CMD_WRITE, 8'hA5, lat);
        chk("wd_ack", 32'(rsp_ack), 32'd1);
        chk("wd_cnt", 32'(wq.size()), 32'd1);
        if (wq.size() > 0) chk("wd_byte", 32'(wq[0]), 32'hA5);

        issue(CMD_STOP, 8'h00, lat);
        chk("sp_lat", 32'(lat), 32'(4 * DIV));
        chk("sp_own", 32'(bus_owned), 32'd0);
        chk("sp_seen", 32'(stops), 32'd1);
        chk("sp_lines", 32'({scl_o, sda_o}), 32'd3);

        issue(CMD_START, 8'h00, lat);
        issue(CMD_WRITE, 8'h45, lat);
        chk("ra_ack", 32'(rsp_ack), 32'd1);
        issue(CMD_READ_ACK, 8'h00, lat);
        chk("r1_data", 32'(rsp_data), 32'h5A);
        chk("r1_ack", 32'(rsp_ack), 32'd1);
        chk("r1_sda", 32'(sda_o), 32'd0);
        issue(CMD_READ_NAK, 8'h00, lat);
        chk("r2_data", 32'(rsp_data), 32'hC3);
        chk("r2_ack", 32'(rsp_ack), 32'd0);
        chk("r2_sda", 32'(sda_o), 32'd1);
        issue(CMD_STOP, 8'h00, lat);

        issue(CMD_START, 8'h00, lat);
        fork
            issue(CMD_WRITE, 8'h44, lat);
            begin : stretch_blk
                wait_scl_rises(5);
                stretch = 1'b1;
                repeat (20) @(posedge clk);
                #1 stretch = 1'b0;
            end
        join
        chk("str_lat", 32'(lat), 32'(36 * DIV + 20));
        chk("str_ack", 32'(rsp_ack), 32'd1);
        chk("str_addr", 32'({sel, rd_mode}), 32'd2);
        issue(CMD_WRITE, 8'h3C, lat);
        chk("str_byte", 32'(wq[wq.size() - 1]), 32'h3C);
        issue(CMD_STOP, 8'h00, lat);

        issue(CMD_START, 8'h00, lat);
        @(posedge clk);
        #1 force0 = 1'b1;
        issue(CMD_WRITE, 8'hFF, lat);
        chk("arb_lat", 32'(lat), 32'(3 * DIV));
        chk("arb_err", 32'(rsp_err), 32'd1);
        chk("arb_lines", 32'({scl_o, sda_o}), 32'd3);
        chk("arb_own", 32'(bus_owned), 32'd0);
        @(posedge clk);
        #1 force0 = 1'b0;

        issue(CMD_START, 8'h00, lat);
        issue(CMD_WRITE, 8'h45, lat);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd = CMD_READ_ACK;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_scl_rises(2);
        repeat (12) @(posedge clk);
        #2 chk("mrst_pre", 32'(scl_o), 32'd0);
        base = nrsp;
        rst_n = 1'b0;
        #1 chk("mrst_lines", 32'({scl_o, sda_o}), 32'd3);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1 chk("mrst_norsp", 32'(nrsp - base), 32'd0);
        chk("mrst_state", 32'({cmd_ready, bus_owned}), 32'd2);
        issue(CMD_START, 8'h00, lat);
        chk("mrst_st_lat", 32'(lat), 32'(4 * DIV));
        chk("mrst_st", 32'({rsp_err, bus_owned}), 32'd1);
        issue(CMD_STOP, 8'h00, lat);
        chk("mrst_sp", 32'(bus_owned), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
